// File: rtl/mat_loader.sv
// mat_loader: accepts a valid/ready element stream, fills mat1 then mat2 in row-major
// order, holds both for the multiplier and pulses run_done. Optional framing check: MAT_LOADER_LAST_CHECK_EN.
module mat_loader #(
    parameter int N_ROWS     = 3,
    parameter int N_COLUMNS  = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    input  logic signed [DATA_WIDTH-1:0]                     in_data,
    output logic [N_ROWS-1:0][N_COLUMNS-1:0][DATA_WIDTH-1:0] mat1,
    output logic [N_ROWS-1:0][N_COLUMNS-1:0][DATA_WIDTH-1:0] mat2,
    output logic                                             enable_mult,
    input  logic                                             mult_done,
    output logic                                             run_done,
    output logic                                             busy
`ifdef MAT_LOADER_LAST_CHECK_EN
    ,
    input  logic                                             in_last,
    output logic                                             frame_err
`endif
);

    localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int COL_W = (N_COLUMNS > 1) ? $clog2(N_COLUMNS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(N_COLUMNS - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_next_row;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_next_col;
    logic             r_enable_mult;
    logic             r_run_done;
    logic             w_loading;
    logic             w_accept;
    logic             w_last_elem;
    logic             w_frame_mismatch;
    logic             w_store;

    logic [N_ROWS-1:0][N_COLUMNS-1:0][DATA_WIDTH-1:0] r_mat1;
    logic [N_ROWS-1:0][N_COLUMNS-1:0][DATA_WIDTH-1:0] r_mat2;

    assign w_loading   = (r_state == LOAD_A) || (r_state == LOAD_B);
    assign in_ready    = w_loading && !reset;
    assign w_accept    = in_valid && in_ready;
    assign w_last_elem = (r_row == ROW_LAST) && (r_col == COL_LAST);

    // A framing mismatch drops the element and restarts the pair from mat1[0][0].
`ifdef MAT_LOADER_LAST_CHECK_EN
    assign w_frame_mismatch = w_accept && (in_last != w_last_elem);
`else
    assign w_frame_mismatch = 1'b0;
`endif

    assign w_store = w_accept && !w_frame_mismatch;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave a value unassigned and infer a latch.
        w_next_state = r_state;
        unique case (r_state)
            LOAD_A: begin
                if (w_frame_mismatch) begin
                    w_next_state = LOAD_A;
                end else if (w_accept && w_last_elem) begin
                    w_next_state = LOAD_B;
                end
            end
            LOAD_B: begin
                if (w_frame_mismatch) begin
                    w_next_state = LOAD_A;
                end else if (w_accept && w_last_elem) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (mult_done) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = LOAD_A;
            end
            default: begin
                w_next_state = LOAD_A;
            end
        endcase
    end

    // Row/col counters walk the matrix in row-major order without any division.
    always_comb begin
        w_next_row = r_row;
        w_next_col = r_col;
        if (w_frame_mismatch) begin
            w_next_row = '0;
            w_next_col = '0;
        end else if (w_accept) begin
            if (r_col == COL_LAST) begin
                w_next_col = '0;
                w_next_row = (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
            end else begin
                w_next_col = r_col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            r_state       <= LOAD_A;
            r_row         <= '0;
            r_col         <= '0;
            r_enable_mult <= 1'b0;
            r_run_done    <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_row         <= w_next_row;
            r_col         <= w_next_col;
            r_enable_mult <= (w_next_state == RUN);
            r_run_done    <= (w_next_state == DONE);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the operand arrays are reset because a reset must discard any
        // partially loaded pair, not just rewind the counters.
        if (reset) begin
            r_mat1 <= '0;
            r_mat2 <= '0;
        end else if (w_store) begin
            if (r_state == LOAD_A) begin
                r_mat1[r_row][r_col] <= in_data;
            end else begin
                r_mat2[r_row][r_col] <= in_data;
            end
        end
    end

`ifdef MAT_LOADER_LAST_CHECK_EN
    logic r_frame_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_frame_mismatch;
        end
    end

    assign frame_err = r_frame_err;
`endif

    assign mat1        = r_mat1;
    assign mat2        = r_mat2;
    assign enable_mult = r_enable_mult;
    assign run_done    = r_run_done;
    assign busy        = (r_state != LOAD_A) || (r_row != '0) || (r_col != '0);

endmodule

// File: tb/tb_mat_loader.sv
// tb_mat_loader: directed self-checking bench for mat_loader (3x2 operands, 32-bit elements).
module tb_mat_loader;

    localparam int NR = 3;
    localparam int NC = 2;
    localparam int DW = 32;

    logic                          clk;
    logic                          reset;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [DW-1:0]          in_data;
    logic [NR-1:0][NC-1:0][DW-1:0] mat1;
    logic [NR-1:0][NC-1:0][DW-1:0] mat2;
    logic                          enable_mult;
    logic                          mult_done;
    logic                          run_done;
    logic                          busy;
    logic                          in_last;
`ifdef MAT_LOADER_LAST_CHECK_EN
    logic                          frame_err;
`endif

    int checks;
    int failures;
    logic [DW-1:0] exp1 [6];
    logic [DW-1:0] exp2 [6];

    mat_loader #(.N_ROWS(NR), .N_COLUMNS(NC), .DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .mat1        (mat1),
        .mat2        (mat2),
        .enable_mult (enable_mult),
        .mult_done   (mult_done),
        .run_done    (run_done),
        .busy        (busy)
`ifdef MAT_LOADER_LAST_CHECK_EN
        ,
        .in_last     (in_last),
        .frame_err   (frame_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] v, input logic last);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = v;
        in_last  = last;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout observed in_ready=0 expected in_ready=1");
        end
        tick();
    endtask

    task automatic load_stream();
        for (int i = 0; i < 6; i++) send(exp1[i], i == 5);
        for (int i = 0; i < 6; i++) send(exp2[i], i == 5);
    endtask

    task automatic check_mats(input string tag);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("%s mat1[%0d][%0d]", tag, i / NC, i % NC), mat1[i / NC][i % NC], exp1[i]);
            check($sformatf("%s mat2[%0d][%0d]", tag, i / NC, i % NC), mat2[i / NC][i % NC], exp2[i]);
        end
    endtask

    task automatic finish_run(input string tag);
        mult_done = 1'b1;
        tick();
        check({tag, " run_done_pulse"}, 32'(run_done), 32'd1);
        check({tag, " enable_drop"}, 32'(enable_mult), 32'd0);
        check({tag, " ready_in_done"}, 32'(in_ready), 32'd0);
        mult_done = 1'b0;
        in_valid  = 1'b0;
        tick();
        check({tag, " run_done_clear"}, 32'(run_done), 32'd0);
        check({tag, " ready_back"}, 32'(in_ready), 32'd1);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        mult_done = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst ready_low", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("rst ready_high", 32'(in_ready), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst enable", 32'(enable_mult), 32'd0);
        check("rst run_done", 32'(run_done), 32'd0);
        for (int i = 0; i < 6; i++) begin
            exp1[i] = '0;
            exp2[i] = '0;
        end
        check_mats("rst");

        // Basic load with a stray mult_done held high through LOAD_A and LOAD_B
        exp1 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
        exp2 = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd0};
        mult_done = 1'b1;
        for (int i = 0; i < 6; i++) send(exp1[i], i == 5);
        check("stray busy_in_b", 32'(busy), 32'd1);
        check("stray ready_in_b", 32'(in_ready), 32'd1);
        check("stray enable_in_b", 32'(enable_mult), 32'd0);
        check("stray run_done_a", 32'(run_done), 32'd0);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) mult_done = 1'b0;
            send(exp2[i], i == 5);
            check($sformatf("stray run_done_b%0d", i), 32'(run_done), 32'd0);
        end
        check("basic enable_rise", 32'(enable_mult), 32'd1);
        check("basic ready_low", 32'(in_ready), 32'd0);
        check("basic busy_run", 32'(busy), 32'd1);
        check_mats("basic");

        // Hold in RUN with a pending 99 on the input
        in_valid = 1'b1;
        in_data  = 32'd99;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("hold enable_c%0d", k + 2), 32'(enable_mult), 32'd1);
            check($sformatf("hold ready_c%0d", k + 2), 32'(in_ready), 32'd0);
            check($sformatf("hold run_done_c%0d", k + 2), 32'(run_done), 32'd0);
        end
        finish_run("hold");
        check_mats("hold");

        // Backpressure: valid pattern 1,0,0 per element, all elements 7
        for (int i = 0; i < 6; i++) begin
            exp1[i] = 32'd7;
            exp2[i] = 32'd7;
        end
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd7;
            in_last  = (i == 5) || (i == 11);
            check($sformatf("gap enable_before_%0d", i), 32'(enable_mult), 32'd0);
            tick();
            if (i < 11) begin
                in_valid = 1'b0;
                tick();
                tick();
            end
        end
        check("gap enable_rise", 32'(enable_mult), 32'd1);
        check("gap ready_low", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        check_mats("gap");
        finish_run("gap");

        // Reset in the middle of loading mat2
        for (int i = 0; i < 9; i++) send(32'd10 + 32'(i), i == 5);
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        check("midrst ready_low", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst ready", 32'(in_ready), 32'd1);
        check("midrst enable", 32'(enable_mult), 32'd0);
        for (int i = 0; i < 6; i++) begin
            exp1[i] = '0;
            exp2[i] = '0;
        end
        check_mats("midrst_clear");
        exp1 = '{32'hffffffff, 32'hfffffffe, 32'h7fffffff, 32'h80000000, 32'd3, 32'd9};
        exp2 = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15};
        load_stream();
        check("reload enable", 32'(enable_mult), 32'd1);
        in_valid = 1'b0;
        check_mats("reload");
        finish_run("reload");

`ifdef MAT_LOADER_LAST_CHECK_EN
        // Early in_last on the 4th mat1 element
        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        send(32'h33, 1'b0);
        send(32'h44, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("frame err_pulse", 32'(frame_err), 32'd1);
        check("frame busy_clear", 32'(busy), 32'd0);
        check("frame ready", 32'(in_ready), 32'd1);
        check("frame kept_00", mat1[0][0], 32'h11);
        check("frame kept_11", mat1[1][1], 32'h80000000);
        tick();
        check("frame err_clear", 32'(frame_err), 32'd0);
        exp1 = '{32'd21, 32'd22, 32'd23, 32'd24, 32'd25, 32'd26};
        exp2 = '{32'd31, 32'd32, 32'd33, 32'd34, 32'd35, 32'd36};
        load_stream();
        check("frame enable", 32'(enable_mult), 32'd1);
        check("frame no_err", 32'(frame_err), 32'd0);
        in_valid = 1'b0;
        check_mats("framed");
        finish_run("framed");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
